// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU control blocks: requester count, select width,
// sequencer state codes and the default WAIT timeout.
package alu_ctrl_pkg;

    localparam int SEL_W       = 2;
    localparam int NUM_REQ     = 4;
    localparam int TIMEOUT_DEF = 15;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

endpackage

// File: rtl/alu_rr_arbiter_if.sv
// Request/ALU/result bundle between the round-robin sequencer (master)
// and the requesters plus ALU datapath (slave).
interface alu_rr_arbiter_if #(parameter int DATA_W = 4);
    import alu_ctrl_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic               alu_done;
    logic [DATA_W-1:0]  alu_result;
    logic [SEL_W-1:0]   mux_sel;
    logic [NUM_REQ-1:0] grant;
    logic               alu_start;
    logic [NUM_REQ-1:0] ack;
    logic [DATA_W-1:0]  result;
    logic [SEL_W-1:0]   result_id;
    logic               result_valid;
    logic               timeout_err;
    logic               busy;

    modport master (
        input  req, alu_done, alu_result,
        output mux_sel, grant, alu_start, ack, result, result_id,
               result_valid, timeout_err, busy
    );

    modport slave (
        output req, alu_done, alu_result,
        input  mux_sel, grant, alu_start, ack, result, result_id,
               result_valid, timeout_err, busy
    );

endinterface

// File: rtl/alu_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after 'last', wrapping.
// Shared by every arbiter that fronts a single resource in the ALU top.
module rr_pick
    import alu_ctrl_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   last,
    output logic               any,
    output logic [SEL_W-1:0]   idx,
    output logic [NUM_REQ-1:0] onehot
);

    logic [SEL_W-1:0] cand;
    logic             found;

    always_comb begin
        any   = |req;
        idx   = '0;
        cand  = '0;
        found = 1'b0;
        // i = NUM_REQ wraps back to 'last' itself, so it has lowest priority
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = last + SEL_W'(i);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        onehot = any ? (NUM_REQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Shares one ALU among four requesters: round-robin grant, start pulse,
// wait for done or timeout, then return the tagged result with an ack.
//
//   state   | meaning
//   IDLE    | no op in flight; requests evaluated here only
//   ISSUE   | grant/mux_sel valid, alu_start pulsed, timeout counter cleared
//   WAIT    | waiting for alu_done, counting toward TIMEOUT
//   DONE    | result_valid + ack for one cycle, grant released on exit
module alu_rr_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_W  = 4,
    parameter int TIMEOUT = TIMEOUT_DEF
)
(
    input  logic                clk,
    input  logic                rst_n,
    alu_rr_arbiter_if.master    bus
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  result_q, result_d;
    logic [SEL_W-1:0]   result_id_q, result_id_d;
    logic               to_q, to_d;

    logic               pick_any;
    logic [SEL_W-1:0]   pick_idx;
    logic [NUM_REQ-1:0] pick_onehot;

    rr_pick u_pick (
        .req    (bus.req),
        .last   (last_q),
        .any    (pick_any),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            sel_q       <= '0;
            last_q      <= SEL_W'(NUM_REQ - 1);
            cnt_q       <= '0;
            result_q    <= '0;
            result_id_q <= '0;
            to_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            sel_q       <= sel_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            result_id_q <= result_id_d;
            to_q        <= to_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        sel_d       = sel_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        result_id_d = result_id_q;
        to_d        = to_q;
        case (state_q)
            S_IDLE: begin
                if (pick_any) begin
                    state_d = S_ISSUE;
                    grant_d = pick_onehot;
                    sel_d   = pick_idx;
                    last_d  = pick_idx;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            S_WAIT: begin
                if (bus.alu_done) begin
                    state_d     = S_DONE;
                    result_d    = bus.alu_result;
                    result_id_d = sel_q;
                    to_d        = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    // TIMEOUT-th WAIT cycle without done: abort with a zero result
                    state_d     = S_DONE;
                    result_d    = '0;
                    result_id_d = sel_q;
                    to_d        = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                grant_d = '0;
                sel_d   = '0;
                to_d    = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.mux_sel      = sel_q;
        bus.grant        = grant_q;
        bus.alu_start    = (state_q == S_ISSUE);
        bus.ack          = (state_q == S_DONE) ? grant_q : '0;
        bus.result       = result_q;
        bus.result_id    = result_id_q;
        bus.result_valid = (state_q == S_DONE);
        bus.timeout_err  = (state_q == S_DONE) && to_q;
        bus.busy         = (state_q != S_IDLE);
    end

endmodule

// File: doc/alu_rr_arbiter.md
# alu_rr_arbiter

Round-robin arbiter and sequencer that shares the single ALU datapath among four requesters. It picks one pending requester, drives the 2-bit select of the ALU's 4:1 4-bit operand multiplexer, and issues a start pulse. It then waits for the ALU's done strobe, or a timeout, and returns the registered result tagged with the requester ID. It sits between the four request sources and the ALU/mux datapath in the ALU top level.

## Interface
- DATA_W, 4, width of ALU result
- TIMEOUT, 15, max cycles in WAIT before abort (1..255)
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req  in  4  request per requester; bit i = requester i
- alu_done  in  1  ALU completion strobe, one cycle
- alu_result  in  DATA_W  ALU result, valid when alu_done=1
- mux_sel  out  2  select to the operand mux; 00=req0 … 11=req3
- grant  out  4  one-hot grant, held from ISSUE through DONE
- alu_start  out  1  one-cycle start pulse to the ALU
- ack  out  4  one-hot one-cycle completion pulse to the granted requester
- result  out  DATA_W  captured ALU result
- result_id  out  2  requester index of result
- result_valid  out  1  one-cycle qualifier for result/result_id
- timeout_err  out  1  high with result_valid when the op aborted on timeout
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE. Encoding is 2-bit binary, from the package.
- IDLE: if req≠0, pick the winner with rr_pick, register grant/mux_sel, go to ISSUE. If req=0, stay.
- Round-robin: search starts at last_grant+1 and wraps 3→0. last_grant updates on each IDLE→ISSUE transition. Reset value of last_grant is 3, so req0 has top priority after reset.
- ISSUE: alu_start=1 for exactly this cycle; go to WAIT. Clear timeout counter. alu_done is ignored in ISSUE.
- WAIT: if alu_done=1, capture alu_result into result and go to DONE with timeout_err=0. Otherwise increment the counter. When the counter reaches TIMEOUT with no done, go to DONE with timeout_err=1 and result=0.
- DONE: result_valid=1, ack[grant]=1, result_id=mux_sel for one cycle; return to IDLE. grant/mux_sel clear to 0 on the exit edge.
- Requester dropping req after grant does not cancel the op; it completes and acks normally.
- A new request arriving during a busy cycle waits; it is evaluated only in IDLE.
- alu_done outside WAIT is ignored and is never counted for a later op.
- result and result_id hold their last value after DONE until the next capture. timeout_err is 0 except in DONE.

## Timing
- Reset values: mux_sel=0, grant=0, alu_start=0, ack=0, result=0, result_id=0, result_valid=0, timeout_err=0, busy=0, state=IDLE, last_grant=3, counter=0.
- rst_n low at any point (mid-op included) forces reset values immediately, asynchronously. The in-flight op is dropped with no ack. The first edge after release evaluates IDLE.
- Cycle n: req sampled in IDLE. n+1: ISSUE (alu_start, mux_sel valid). n+2: first WAIT cycle.
- If alu_done is high in WAIT cycle k, result_valid is high in cycle k+1. Minimum req→result_valid latency is 3 cycles.
- Timeout: done absent for TIMEOUT WAIT cycles gives DONE on the next cycle; WAIT lasts exactly TIMEOUT cycles.
- Back-to-back: from DONE, IDLE, then the next ISSUE. Per-grant overhead is 1 IDLE cycle, so minimum throughput is one op per 4 cycles.
- mux_sel is stable from ISSUE through DONE inclusive, so the ALU operand is glitch-free during the op.

## Structure
- Shared package alu_ctrl_pkg holds:
  - state localparams (S_IDLE=0, S_ISSUE=1, S_WAIT=2, S_DONE=3)
  - SEL_W=2 and NUM_REQ=4
  - the default TIMEOUT constant
- Sub-module rr_pick: combinational; inputs req[3:0] and last[1:0]; outputs any, idx[1:0] and onehot[3:0]. Reusable by other shared-resource arbiters in the ALU top.
- Counter width is $clog2(TIMEOUT+1).

## Test plan
- Reset, then req=0001; alu_done=1 with alu_result=4'hA on the first WAIT cycle. Expect: alu_start at cycle 1, mux_sel=00, result_valid at cycle 3, result=A, result_id=0, ack=0001.
- req=1111 held for four ops with immediate done. Expect grant order 0,1,2,3, then back to 0; mux_sel follows it.
- Grant to req2, then req drops to 0 in WAIT; done after 5 cycles with 4'h3. Expect the op completes, ack=0100, result=3.
- No alu_done with TIMEOUT=15. Expect exactly 15 WAIT cycles, then result_valid=1, timeout_err=1, result=0, ack to the granted requester.
- rst_n pulsed low during WAIT for req1. Expect all outputs at reset values asynchronously and no ack. After release with req=0011, expect req0 to be granted first.
- Stray alu_done in IDLE and ISSUE, then a real done in WAIT. Expect only the WAIT done to be captured; single result_valid.
